stopwatch_core: RTL and testbench
=================================

# stopwatch_core

Centisecond stopwatch that produces the four BCD digits (SS.cc, 00.00–99.99) feeding the 7-segment display multiplexer. It sits directly upstream of the display mux: hex3..hex0 connect one-to-one to the mux digit inputs, and the mux's fixed decimal point on digit 1 forms "SS.cc". Raw button levels come in; the block synchronises them, runs a start/stop/lap/clear state machine, and counts in BCD from a prescaled tick.

## Interface
- TICK_DIV, 1_000_000: clk cycles per centisecond tick (100 MHz / 100 Hz); benches use 4.
- clk  in  1  system clock, 100 MHz
- rst_n  in  1  reset, asynchronous, active-low
- btn_ss  in  1  start/stop button level, asynchronous to clk
- btn_lap  in  1  lap button level, asynchronous
- btn_clr  in  1  clear button level, asynchronous
- hex3  out  4  seconds tens (BCD)
- hex2  out  4  seconds units
- hex1  out  4  centiseconds tens
- hex0  out  4  centiseconds units
- running  out  1  high in RUN or LAP
- lap_active  out  1  high in LAP (display frozen)
- wrapped  out  1  sticky; set on 99.99→00.00 rollover

## Operation
- Each button passes through a 2-flop synchroniser, then a rising-edge detector, giving a 1-cycle pulse per press. No debouncing in this block.
- States: IDLE, RUN, PAUSE, LAP.
  - IDLE: ss→RUN.
  - RUN: ss→PAUSE; lap→LAP (snapshot the count).
  - LAP: lap→RUN (live display resumes); ss→PAUSE (live display).
  - PAUSE: ss→RUN; clr→IDLE.
- clr is ignored in RUN and LAP; lap is ignored in IDLE and PAUSE.
- Simultaneous pulses: priority is clr > ss > lap. Only one transition occurs per cycle.
- Prescaler width is $clog2(TICK_DIV).
  - It counts only in RUN or LAP, and holds in PAUSE, so partial ticks are kept.
  - It clears on entry to IDLE.
  - tick fires when prescaler == TICK_DIV-1; the prescaler then returns to 0.
- BCD chain on tick:
  - d0 increments; at 9 it goes to 0 and carries into d1.
  - d1 wraps 9→0 and carries into d2; d2 likewise into d3.
  - d3 wraps 9→0.
  - Each digit is always in 0–9.
- Rollover from 99.99 goes to 00.00, sets wrapped, and counting continues.
- Display:
  - hex = snapshot when in LAP, else the live count.
  - The snapshot is loaded on the RUN→LAP edge. If a tick occurs in the same cycle, the snapshot takes the pre-tick value.
- clr (PAUSE→IDLE) zeroes the digits, snapshot, prescaler and wrapped.

## Timing
- Reset values: all hex = 0, running = 0, lap_active = 0, wrapped = 0, state IDLE, prescaler 0.
- Button latency:
  - A level rising before clk edge N produces an edge pulse in the cycle after edge N+2.
  - The state change is visible after edge N+3.
- Tick to display: a digit register updates on the same edge as the tick. hex reflects it with no extra register (combinational mux only).
- First tick arrives TICK_DIV cycles after entering RUN.
- running and lap_active are decoded combinationally from the state register.
- Async reset mid-count returns everything to reset values immediately. The count is not retained.

## Structure
- Shared package stopwatch_pkg holds:
  - State enum encoding (IDLE=0, RUN=1, PAUSE=2, LAP=3).
  - Default TICK_DIV constant.
  - BCD_MAX = 4'd9.
- Sub-module btn_sync_edge (2FF synchroniser + edge detector, asynchronous reset, output pulse) is instantiated three times.
- The BCD chain and state machine stay inline.

## Test plan
All scenarios use TICK_DIV=4.
- Reset: hold rst_n low, toggle buttons → hex3..0 = 0,0,0,0; running = 0; wrapped = 0.
- Start: press ss, then 40 cycles after RUN entry → hex1 = 1, hex0 = 0, running = 1. A further press of ss gives PAUSE; the value holds for 100 cycles.
- Carry: run to 09.99, one more tick → hex3 = 1, hex2 = 0, hex1 = 0, hex0 = 0.
- Wrap: run to 99.99, one tick → all hex = 0, wrapped = 1, counting continues (00.01 after 4 more cycles). clr in PAUSE clears wrapped.
- Lap: lap at 00.12 → hex stays 00.12 for 40 cycles while the internal count advances. Second lap → hex shows live 00.22. lap_active follows.
- Priority and clear:
  - clr+ss on the same cycle in PAUSE → IDLE, count 00.00.
  - clr in RUN is ignored.
  - rst_n pulse mid-RUN → all outputs zero and state IDLE.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg
// Shared types and constants for the centisecond stopwatch:
//   state_t          - control FSM encoding (IDLE=0, RUN=1, PAUSE=2, LAP=3)
//   bcd4_t           - four packed BCD digits {d3,d2,d1,d0} = SS.cc
//   TICK_DIV_DEFAULT - clk cycles per centisecond at 100 MHz
//   BCD_MAX          - largest legal BCD digit
//   bcd_inc()        - ripple-carry BCD increment with 99.99 -> 00.00 wrap
package stopwatch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_LAP   = 2'd3
  } state_t;

  typedef struct packed {
    logic [3:0] d3;
    logic [3:0] d2;
    logic [3:0] d1;
    logic [3:0] d0;
  } bcd4_t;

  localparam int         TICK_DIV_DEFAULT = 1_000_000;
  localparam logic [3:0] BCD_MAX          = 4'd9;
  localparam bcd4_t      BCD_FULL         = 16'h9999;

  // Each digit rolls 9 -> 0 and carries into the next; d3 rolls with no carry out.
  function automatic bcd4_t bcd_inc(input bcd4_t v);
    bcd4_t r;
    r = v;
    if (v.d0 != BCD_MAX) begin
      r.d0 = v.d0 + 4'd1;
    end else begin
      r.d0 = 4'd0;
      if (v.d1 != BCD_MAX) begin
        r.d1 = v.d1 + 4'd1;
      end else begin
        r.d1 = 4'd0;
        if (v.d2 != BCD_MAX) begin
          r.d2 = v.d2 + 4'd1;
        end else begin
          r.d2 = 4'd0;
          r.d3 = (v.d3 != BCD_MAX) ? v.d3 + 4'd1 : 4'd0;
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/stopwatch_core_if.sv
// stopwatch_core_if
// Groups the stopwatch's user-facing signals.
//   btn_ss / btn_lap / btn_clr : raw button levels, asynchronous to clk
//   hex3..hex0                 : displayed BCD digits, hex3 = seconds tens
//   running / lap_active       : state flags for indicators
//   wrapped                    : sticky 99.99 -> 00.00 rollover flag
// There is no valid/ready handshake here: buttons are plain levels sampled
// through synchronisers, and the display outputs are continuously valid.
// master = the button/display side, slave = the stopwatch core.
interface stopwatch_core_if;
  logic       btn_ss;
  logic       btn_lap;
  logic       btn_clr;
  logic [3:0] hex3;
  logic [3:0] hex2;
  logic [3:0] hex1;
  logic [3:0] hex0;
  logic       running;
  logic       lap_active;
  logic       wrapped;

  modport master (
    output btn_ss, btn_lap, btn_clr,
    input  hex3, hex2, hex1, hex0, running, lap_active, wrapped
  );

  modport slave (
    input  btn_ss, btn_lap, btn_clr,
    output hex3, hex2, hex1, hex0, running, lap_active, wrapped
  );
endinterface

// File: rtl/stopwatch_core_btn_sync_edge.sv
// btn_sync_edge
// Two-flop synchroniser followed by a registered rising-edge detector.
//   clk, rst_n : clock, asynchronous active-low reset
//   btn        : raw asynchronous button level
//   pulse      : one-cycle pulse per rising edge of btn
// A level rising before edge N gives a pulse in the cycle after edge N+2.
module btn_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic pulse
);
  logic [1:0] sync_q;
  logic       prev_q;
  logic       pulse_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= 2'b00;
      prev_q  <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], btn};
      prev_q  <= sync_q[1];
      pulse_q <= sync_q[1] & ~prev_q;
    end
  end

  assign pulse = pulse_q;
endmodule

// File: rtl/stopwatch_core.sv
// stopwatch_core
// Centisecond stopwatch producing SS.cc as four BCD digits (00.00-99.99).
//   clk, rst_n : 100 MHz clock, asynchronous active-low reset
//   bus        : stopwatch_core_if.slave - buttons in, digits/flags out
//   state_dbg  : current FSM state, for observation
// Buttons are synchronised and edge-detected, drive an IDLE/RUN/PAUSE/LAP
// machine, and a prescaler generates the centisecond tick for the BCD chain.
module stopwatch_core
  import stopwatch_pkg::*;
#(
  parameter int TICK_DIV = TICK_DIV_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  stopwatch_core_if.slave  bus,
  output state_t           state_dbg
);
  localparam int            PW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  logic          ss_p, lap_p, clr_p;
  state_t        state_q, state_d;
  logic [PW-1:0] presc_q;
  bcd4_t         count_q, snap_q, disp;
  logic          wrapped_q;
  logic          counting, tick, clr_now, lap_enter;

  btn_sync_edge u_ss  (.clk(clk), .rst_n(rst_n), .btn(bus.btn_ss),  .pulse(ss_p));
  btn_sync_edge u_lap (.clk(clk), .rst_n(rst_n), .btn(bus.btn_lap), .pulse(lap_p));
  btn_sync_edge u_clr (.clk(clk), .rst_n(rst_n), .btn(bus.btn_clr), .pulse(clr_p));

  // Next state. Within each state only the buttons that matter are examined,
  // in clr > ss > lap order, so an ignored button never masks a live one.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (ss_p) state_d = ST_RUN;
      ST_RUN:   if (ss_p) state_d = ST_PAUSE;
                else if (lap_p) state_d = ST_LAP;
      ST_LAP:   if (ss_p) state_d = ST_PAUSE;
                else if (lap_p) state_d = ST_RUN;
      ST_PAUSE: if (clr_p) state_d = ST_IDLE;
                else if (ss_p) state_d = ST_RUN;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  assign counting  = (state_q == ST_RUN) || (state_q == ST_LAP);
  assign tick      = counting && (presc_q == PRESC_LAST);
  assign clr_now   = (state_q == ST_PAUSE) && (state_d == ST_IDLE);
  assign lap_enter = (state_q == ST_RUN) && (state_d == ST_LAP);

  // Prescaler holds in PAUSE so a partial tick survives stop/start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
    end else if (clr_now) begin
      presc_q <= '0;
    end else if (counting) begin
      presc_q <= tick ? '0 : presc_q + PW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q   <= '0;
      wrapped_q <= 1'b0;
    end else if (clr_now) begin
      count_q   <= '0;
      wrapped_q <= 1'b0;
    end else if (tick) begin
      count_q <= bcd_inc(count_q);
      if (count_q == BCD_FULL) wrapped_q <= 1'b1;
    end
  end

  // Snapshot takes count_q before any same-cycle tick lands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snap_q <= '0;
    end else if (clr_now) begin
      snap_q <= '0;
    end else if (lap_enter) begin
      snap_q <= count_q;
    end
  end

  assign disp           = (state_q == ST_LAP) ? snap_q : count_q;
  assign bus.hex3       = disp.d3;
  assign bus.hex2       = disp.d2;
  assign bus.hex1       = disp.d1;
  assign bus.hex0       = disp.d0;
  assign bus.running    = counting;
  assign bus.lap_active = (state_q == ST_LAP);
  assign bus.wrapped    = wrapped_q;
  assign state_dbg      = state_q;
endmodule

// File: tb/tb_stopwatch_core.sv
module tb_stopwatch_core;
  import stopwatch_pkg::*;

  logic   clk;
  logic   rst_n;
  state_t state_dbg;
  int     checks;
  int     failures;

  stopwatch_core_if sw_if ();

  stopwatch_core #(.TICK_DIV(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (sw_if),
    .state_dbg (state_dbg)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] hex_word();
    return {sw_if.hex3, sw_if.hex2, sw_if.hex1, sw_if.hex0};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Driver: assert the chosen buttons for one cycle, then wait until the
  // resulting state change has landed (edge N+3 after the first sampling edge N).
  task automatic press(input logic ss, input logic lap, input logic clr);
    @(negedge clk);
    sw_if.btn_ss  = ss;
    sw_if.btn_lap = lap;
    sw_if.btn_clr = clr;
    @(negedge clk);
    sw_if.btn_ss  = 1'b0;
    sw_if.btn_lap = 1'b0;
    sw_if.btn_clr = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    sw_if.btn_ss  = 1'b0;
    sw_if.btn_lap = 1'b0;
    sw_if.btn_clr = 1'b0;

    // Reset: buttons wiggle while rst_n is held low
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      sw_if.btn_ss  = i[0];
      sw_if.btn_lap = i[1];
      sw_if.btn_clr = ~i[0];
    end
    @(negedge clk);
    check("rst_hex", 32'(hex_word()), 32'h0000);
    check("rst_running", 32'(sw_if.running), 32'd0);
    check("rst_wrapped", 32'(sw_if.wrapped), 32'd0);
    check("rst_lap_active", 32'(sw_if.lap_active), 32'd0);
    check("rst_state", 32'(state_dbg), 32'(ST_IDLE));
    sw_if.btn_ss  = 1'b0;
    sw_if.btn_lap = 1'b0;
    sw_if.btn_clr = 1'b0;
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("post_rst_state", 32'(state_dbg), 32'(ST_IDLE));

    // Start: RUN entered at edge E; ticks at E+4k
    press(1'b1, 1'b0, 1'b0);
    check("start_state", 32'(state_dbg), 32'(ST_RUN));
    check("start_hex_at_entry", 32'(hex_word()), 32'h0000);
    repeat (40) @(negedge clk);
    check("start_hex_40", 32'(hex_word()), 32'h0010);
    check("start_running", 32'(sw_if.running), 32'd1);
    // Pause lands at E+45; tick at E+44 gives 00.11
    press(1'b1, 1'b0, 1'b0);
    check("pause_state", 32'(state_dbg), 32'(ST_PAUSE));
    check("pause_hex", 32'(hex_word()), 32'h0011);
    repeat (100) @(negedge clk);
    check("pause_hold_hex", 32'(hex_word()), 32'h0011);
    check("pause_running", 32'(sw_if.running), 32'd0);

    // clr + ss together in PAUSE: clear wins
    press(1'b1, 1'b0, 1'b1);
    check("clr_ss_state", 32'(state_dbg), 32'(ST_IDLE));
    check("clr_ss_hex", 32'(hex_word()), 32'h0000);

    // Carry: 999th tick at E+3996, 1000th at E+4000
    press(1'b1, 1'b0, 1'b0);
    repeat (3996) @(negedge clk);
    check("carry_pre", 32'(hex_word()), 32'h0999);
    repeat (4) @(negedge clk);
    check("carry_post", 32'(hex_word()), 32'h1000);
    // clr in RUN is ignored; tick at E+4004
    press(1'b0, 1'b0, 1'b1);
    check("clr_in_run_state", 32'(state_dbg), 32'(ST_RUN));
    check("clr_in_run_hex", 32'(hex_word()), 32'h1001);

    // Wrap: 9999th tick at E+39996
    repeat (39996 - 4005) @(negedge clk);
    check("wrap_pre_hex", 32'(hex_word()), 32'h9999);
    check("wrap_pre_flag", 32'(sw_if.wrapped), 32'd0);
    repeat (4) @(negedge clk);
    check("wrap_hex", 32'(hex_word()), 32'h0000);
    check("wrap_flag", 32'(sw_if.wrapped), 32'd1);
    check("wrap_running", 32'(sw_if.running), 32'd1);
    repeat (4) @(negedge clk);
    check("wrap_continue", 32'(hex_word()), 32'h0001);
    // Pause lands at E+40009; tick at E+40008 gives 00.02
    press(1'b1, 1'b0, 1'b0);
    check("wrap_pause_hex", 32'(hex_word()), 32'h0002);
    check("wrap_pause_flag", 32'(sw_if.wrapped), 32'd1);
    press(1'b0, 1'b0, 1'b1);
    check("clr_state", 32'(state_dbg), 32'(ST_IDLE));
    check("clr_hex", 32'(hex_word()), 32'h0000);
    check("clr_wrapped", 32'(sw_if.wrapped), 32'd0);

    // Lap: RUN at E; LAP lands at E+50 with count 00.12
    press(1'b1, 1'b0, 1'b0);
    repeat (45) @(negedge clk);
    press(1'b0, 1'b1, 1'b0);
    check("lap_state", 32'(state_dbg), 32'(ST_LAP));
    check("lap_active", 32'(sw_if.lap_active), 32'd1);
    check("lap_running", 32'(sw_if.running), 32'd1);
    check("lap_hex", 32'(hex_word()), 32'h0012);
    repeat (36) @(negedge clk);
    check("lap_frozen_hex", 32'(hex_word()), 32'h0012);
    // Back to RUN at E+91; live count is 00.22 (tick at E+88)
    press(1'b0, 1'b1, 1'b0);
    check("lap2_state", 32'(state_dbg), 32'(ST_RUN));
    check("lap2_active", 32'(sw_if.lap_active), 32'd0);
    check("lap2_hex", 32'(hex_word()), 32'h0022);

    // Asynchronous reset mid-run
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("arst_hex", 32'(hex_word()), 32'h0000);
    check("arst_running", 32'(sw_if.running), 32'd0);
    check("arst_lap_active", 32'(sw_if.lap_active), 32'd0);
    check("arst_state", 32'(state_dbg), 32'(ST_IDLE));
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    check("arst_after_hex", 32'(hex_word()), 32'h0000);
    check("arst_after_state", 32'(state_dbg), 32'(ST_IDLE));

    // final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
